mem_store_buffer: RTL

- FIFO store buffer between the MEM pipeline stage and the byte-addressed data RAM.
- Accepts committed stores from MEM and drains them to the RAM write port one per cycle, whenever the shared RAM address port is free.
- Lets loads forward data from buffered stores; stalls loads that only partially overlap a buffered store.
- Outputs drive the RAM's write/address/data/size inputs directly; o_mem_sel steers the RAM address mux.

---
 rtl/mem_store_buffer_if.sv | 44 ++++
 rtl/mem_store_buffer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_store_buffer_if.sv
// Store-buffer bus: MEM-stage store/load ports, RAM write/address port and status.
// master = pipeline/RAM side, slave = the store buffer.
interface mem_store_buffer_if #(
  parameter int W     = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_clk_en;
  logic          i_st_valid;
  logic          o_st_ready;
  logic [W-1:0]  i_st_addr;
  logic [W-1:0]  i_st_data;
  logic [1:0]    i_st_size;
  logic          i_ld_valid;
  logic [W-1:0]  i_ld_addr;
  logic [1:0]    i_ld_size;
  logic          o_ld_hit;
  logic [W-1:0]  o_ld_data;
  logic          o_ld_stall;
  logic          o_mem_sel;
  logic          o_mem_write;
  logic [W-1:0]  o_mem_addr;
  logic [W-1:0]  o_mem_data;
  logic          o_store_byte;
  logic          o_store_half;
  logic [CW-1:0] o_count;
  logic          o_empty;
  logic          o_full;

  modport master (
    output i_clk_en, i_st_valid, i_st_addr, i_st_data, i_st_size,
           i_ld_valid, i_ld_addr, i_ld_size,
    input  o_st_ready, o_ld_hit, o_ld_data, o_ld_stall, o_mem_sel, o_mem_write,
           o_mem_addr, o_mem_data, o_store_byte, o_store_half, o_count, o_empty, o_full
  );

  modport slave (
    input  i_clk_en, i_st_valid, i_st_addr, i_st_data, i_st_size,
           i_ld_valid, i_ld_addr, i_ld_size,
    output o_st_ready, o_ld_hit, o_ld_data, o_ld_stall, o_mem_sel, o_mem_write,
           o_mem_addr, o_mem_data, o_store_byte, o_store_half, o_count, o_empty, o_full
  );
endinterface

// File: rtl/mem_store_buffer.sv
// FIFO store buffer between MEM and the data RAM, with store-to-load forwarding.
// Optional STB_COALESCE_EN: a store matching the youngest entry overwrites it in place.
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif

module mem_store_buffer #(
  parameter logic [1:0] XLEN  = `XLEN_64b,
  parameter int         DEPTH = 4
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mem_store_buffer_if.slave bus
);
  localparam int W  = 1 << (int'(XLEN) + 4);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  addr_q [DEPTH];
  logic [W-1:0]  data_q [DEPTH];
  logic [1:0]    size_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  function automatic logic [3:0] nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  function automatic logic [W-1:0] size_mask(input logic [1:0] size);
    return (W'(1) << (8 * int'(nbytes(size)))) - W'(1);
  endfunction

  // Wrapping ranges overlap iff either start lies inside the other range.
  function automatic logic overlap(input logic [W-1:0] a, input logic [3:0] na,
                                   input logic [W-1:0] b, input logic [3:0] nb);
    logic [W-1:0] d_ba;
    logic [W-1:0] d_ab;
    d_ba = b - a;
    d_ab = a - b;
    return (d_ba < W'(na)) || (d_ab < W'(nb));
  endfunction

  logic          empty, full;
  logic          fwd_hit, fwd_part;
  logic [W-1:0]  fwd_data;
  logic [PW-1:0] idx;
  logic          ld_hit, ld_part, drain_go, coal, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Scan oldest to youngest so the youngest overlapping entry has the last word.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_part = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q &&
          overlap(bus.i_ld_addr, nbytes(bus.i_ld_size), addr_q[idx], nbytes(size_q[idx]))) begin
        if (addr_q[idx] == bus.i_ld_addr && size_q[idx] == bus.i_ld_size) begin
          fwd_hit  = 1'b1;
          fwd_part = 1'b0;
          fwd_data = data_q[idx] & size_mask(size_q[idx]);
        end else begin
          fwd_hit  = 1'b0;
          fwd_part = 1'b1;
          fwd_data = '0;
        end
      end
    end
  end

  assign ld_hit   = bus.i_ld_valid & fwd_hit;
  assign ld_part  = bus.i_ld_valid & fwd_part;
  assign drain_go = bus.i_clk_en & ~empty & (~bus.i_ld_valid | full | ld_part | ld_hit);

`ifdef STB_COALESCE_EN
  logic [PW-1:0] young;
  assign young = tail_q - PW'(1);
  // A single entry that is draining right now cannot absorb the store.
  assign coal  = ~empty && addr_q[young] == bus.i_st_addr && size_q[young] == bus.i_st_size &&
                 !(drain_go && count_q == CW'(1));
`else
  assign coal  = 1'b0;
`endif

  assign push = bus.i_clk_en & bus.i_st_valid & ~full & ~coal;

  assign bus.o_st_ready   = ~full | coal;
  assign bus.o_ld_hit     = ld_hit;
  assign bus.o_ld_data    = ld_hit ? fwd_data : '0;
  assign bus.o_ld_stall   = ld_part | (bus.i_ld_valid & drain_go & ~fwd_hit);
  assign bus.o_mem_sel    = drain_go;
  assign bus.o_mem_write  = drain_go;
  assign bus.o_mem_addr   = drain_go ? addr_q[head_q] : '0;
  assign bus.o_mem_data   = drain_go ? data_q[head_q] : '0;
  assign bus.o_store_byte = drain_go && size_q[head_q] == 2'b00;
  assign bus.o_store_half = drain_go && size_q[head_q] == 2'b01;
  assign bus.o_count      = count_q;
  assign bus.o_empty      = empty;
  assign bus.o_full       = full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
        size_q[k] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q] <= bus.i_st_addr;
        data_q[tail_q] <= bus.i_st_data;
        size_q[tail_q] <= bus.i_st_size;
        tail_q         <= tail_q + PW'(1);
      end
`ifdef STB_COALESCE_EN
      if (bus.i_clk_en && bus.i_st_valid && coal)
        data_q[young] <= bus.i_st_data;
`endif
      if (drain_go)
        head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(drain_go);
    end
  end
endmodule
